// File: rtl/credit_pkg.sv
// Width helpers and default sizing shared between the credit pool and the
// sender scheduler that consumes its pick index and credit counts.
package credit_pkg;

  // Index width that never collapses to zero for a single-channel pool.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_credits);
    return (max_credits < 1) ? 1 : $clog2(max_credits + 1);
  endfunction

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CREDITS_MAX = 8;
  localparam int DEF_INC_W       = 2;
  localparam int DEF_CNT_W       = cnt_width(DEF_CREDITS_MAX);
  localparam int DEF_IDX_W       = idx_width(DEF_NUM_CH);

  typedef logic [DEF_IDX_W-1:0] ch_idx_t;
  typedef logic [DEF_CNT_W-1:0] credit_cnt_t;

endpackage

// File: rtl/credit_chan.sv
// One channel's saturating credit counter with sticky overflow/underflow
// flags; a new error in the same cycle as err_clr keeps its flag set.
module credit_chan
  import credit_pkg::*;
#(
  parameter int CREDITS_MAX  = DEF_CREDITS_MAX,
  parameter int CREDITS_INIT = CREDITS_MAX,
  parameter int INC_W        = DEF_INC_W,
  parameter int CNT_WIDTH    = cnt_width(CREDITS_MAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INC_W-1:0]     add,
  input  logic                 sub,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 has_credits,
  output logic                 full,
  output logic                 ovf_err,
  output logic                 unf_err
);

  localparam int SUM_W = CNT_WIDTH + INC_W + 1;

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sub_w;
  logic [SUM_W-1:0]     diff;

  always_comb begin
    sum     = SUM_W'(count_q) + SUM_W'(add);
    sub_w   = SUM_W'(sub);
    diff    = sum - sub_w;
    count_d = count_q;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    // Returns and consumes net out before saturation is applied.
    if (sum < sub_w) begin
      count_d = '0;
      unf_d   = 1'b1;
    end else if (diff > SUM_W'(CREDITS_MAX)) begin
      count_d = CNT_WIDTH'(CREDITS_MAX);
      ovf_d   = 1'b1;
    end else begin
      count_d = diff[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_WIDTH'(CREDITS_INIT);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count       = count_q;
  assign has_credits = (count_q != '0);
  assign full        = (count_q == CNT_WIDTH'(CREDITS_MAX));
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: rtl/credit_pool.sv
// Multi-channel credit tracker with a round-robin picker that hands out one
// credit per cycle to the scheduler from any channel holding credits.
module credit_pool
  import credit_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CREDITS_MAX  = DEF_CREDITS_MAX,
  parameter int CREDITS_INIT = CREDITS_MAX,
  parameter int INC_W        = DEF_INC_W,
  parameter int CNT_WIDTH    = cnt_width(CREDITS_MAX),
  parameter int IDX_W        = idx_width(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           inc_en,
  input  logic [NUM_CH*INC_W-1:0]     inc_amt,
  input  logic [NUM_CH-1:0]           dec,
  input  logic                        pick_req,
  output logic                        pick_valid,
  output logic [IDX_W-1:0]            pick_idx,
  input  logic                        err_clr,
  output logic [NUM_CH*CNT_WIDTH-1:0] credits,
  output logic [NUM_CH-1:0]           has_credits,
  output logic [NUM_CH-1:0]           full,
  output logic [NUM_CH-1:0]           ovf_err,
  output logic [NUM_CH-1:0]           unf_err
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] pickable;
  logic [IDX_W:0]    cand;
  logic              grant;

  // A channel being consumed directly this cycle is skipped so that no
  // channel ever loses two credits in one cycle.
  always_comb begin
    pickable   = has_credits & ~dec;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CH)) begin
        cand = cand - (IDX_W+1)'(NUM_CH);
      end
      if (!pick_valid && pickable[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant = pick_req & pick_valid;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic [INC_W-1:0] add;
    logic             sub;

    assign add = inc_en[i] ? inc_amt[i*INC_W +: INC_W] : '0;
    assign sub = dec[i] | (grant && (pick_idx == IDX_W'(i)));

    credit_chan #(
      .CREDITS_MAX  (CREDITS_MAX),
      .CREDITS_INIT (CREDITS_INIT),
      .INC_W        (INC_W),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .add         (add),
      .sub         (sub),
      .err_clr     (err_clr),
      .count       (credits[i*CNT_WIDTH +: CNT_WIDTH]),
      .has_credits (has_credits[i]),
      .full        (full[i]),
      .ovf_err     (ovf_err[i]),
      .unf_err     (unf_err[i])
    );
  end

endmodule

// File: tb/tb_credit_pool.sv
// Bench for credit_pool: directed scenarios plus a randomized run checked
// against an integer model of the credit rules.
module tb_credit_pool;

  localparam int NUM_CH = 4;
  localparam int MAXC   = 8;
  localparam int INC_W  = 2;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       inc_en = '0;
  logic [NUM_CH*INC_W-1:0] inc_amt = '0;
  logic [NUM_CH-1:0]       dec = '0;
  logic                    pick_req = 1'b0;
  logic                    err_clr = 1'b0;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_CH*CNT_W-1:0] credits;
  logic [NUM_CH-1:0]       has_credits, full, ovf_err, unf_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_cnt [NUM_CH];
  bit m_ovf [NUM_CH];
  bit m_unf [NUM_CH];
  int m_ptr;

  credit_pool #(
    .NUM_CH(NUM_CH), .CREDITS_MAX(MAXC), .CREDITS_INIT(MAXC), .INC_W(INC_W)
  ) dut (
    .clk(clk), .rst(rst), .inc_en(inc_en), .inc_amt(inc_amt), .dec(dec),
    .pick_req(pick_req), .pick_valid(pick_valid), .pick_idx(pick_idx),
    .err_clr(err_clr), .credits(credits), .has_credits(has_credits),
    .full(full), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, required one");
    $fatal(1);
  end

  // Eligible channel closest to the pointer going upward (modular distance).
  function automatic int m_pick();
    int best  = -1;
    int bestd = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_cnt[c] > 0 && !dec[c]) begin
        int d = (c - m_ptr + NUM_CH) % NUM_CH;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NUM_CH*CNT_W-1:0] exp_credits();
    logic [NUM_CH*CNT_W-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_has();
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = (m_cnt[c] > 0);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_full();
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = (m_cnt[c] == MAXC);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ovf();
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_ovf[c];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_unf();
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_unf[c];
    return r;
  endfunction

  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic tick();
    int p = m_pick();
    bit g = pick_req && (p >= 0);
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = MAXC;
        m_ovf[c] = 1'b0;
        m_unf[c] = 1'b0;
      end
      m_ptr = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        int add = inc_en[c] ? int'(inc_amt[c*INC_W +: INC_W]) : 0;
        int sub = int'(dec[c]) + ((g && p == c) ? 1 : 0);
        int s   = m_cnt[c] + add - sub;
        if (err_clr) begin
          m_ovf[c] = 1'b0;
          m_unf[c] = 1'b0;
        end
        if (s < 0) begin
          m_cnt[c] = 0;
          m_unf[c] = 1'b1;
        end else if (s > MAXC) begin
          m_cnt[c] = MAXC;
          m_ovf[c] = 1'b1;
        end else begin
          m_cnt[c] = s;
        end
      end
      if (g) m_ptr = (p + 1) % NUM_CH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inc_en = '0; inc_amt = '0; dec = '0; pick_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    #2;
    n_cmp++; if (credits !== 16'h8888) begin
      $display("FAIL reset_credits: got %h, required %h", credits, 16'h8888); n_fail++; end
    n_cmp++; if (full !== 4'hf) begin
      $display("FAIL reset_full: got %b, required 1111", full); n_fail++; end
    n_cmp++; if (has_credits !== 4'hf) begin
      $display("FAIL reset_has: got %b, required 1111", has_credits); n_fail++; end
    n_cmp++; if (pick_valid !== 1'b1 || pick_idx !== 2'd0) begin
      $display("FAIL reset_pick: got v=%b idx=%0d, required v=1 idx=0", pick_valid, pick_idx); n_fail++; end
    n_cmp++; if ((ovf_err | unf_err) !== 4'h0) begin
      $display("FAIL reset_err: got ovf=%b unf=%b, required 0", ovf_err, unf_err); n_fail++; end
  endtask

  task automatic test_round_robin();
    pick_req = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      #2;
      n_cmp++; if (pick_valid !== 1'b1 || pick_idx !== IDX_W'(k)) begin
        $display("FAIL rr_pick_%0d: got v=%b idx=%0d, required v=1 idx=%0d", k, pick_valid, pick_idx, k); n_fail++; end
      tick();
    end
    pick_req = 1'b0;
    #2;
    n_cmp++; if (credits !== 16'h7777) begin
      $display("FAIL rr_credits: got %h, required 7777", credits); n_fail++; end
    n_cmp++; if (pick_idx !== 2'd0) begin
      $display("FAIL rr_ptr_wrap: got idx=%0d, required 0", pick_idx); n_fail++; end
  endtask

  task automatic test_underflow();
    dec = 4'b0010;
    for (int k = 0; k < 7; k++) tick();
    n_cmp++; if (credits[7:4] !== 4'd0 || unf_err !== 4'b0000) begin
      $display("FAIL unf_drain: got cnt1=%0d unf=%b, required 0 and 0000", credits[7:4], unf_err); n_fail++; end
    tick();
    n_cmp++; if (credits[7:4] !== 4'd0 || unf_err !== 4'b0010) begin
      $display("FAIL unf_set: got cnt1=%0d unf=%b, required 0 and 0010", credits[7:4], unf_err); n_fail++; end
    dec = '0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (unf_err !== 4'b0000) begin
      $display("FAIL unf_clear: got %b, required 0000", unf_err); n_fail++; end
  endtask

  task automatic test_overflow();
    inc_en  = 4'b0100;
    inc_amt = 8'b0011_0000;
    err_clr = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (credits[11:8] !== 4'd8 || full[2] !== 1'b1) begin
      $display("FAIL ovf_sat: got cnt2=%0d full=%b, required 8 and 1", credits[11:8], full[2]); n_fail++; end
    n_cmp++; if (ovf_err !== 4'b0100) begin
      $display("FAIL ovf_set_with_clr: got %b, required 0100", ovf_err); n_fail++; end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (ovf_err !== 4'b0000) begin
      $display("FAIL ovf_clear: got %b, required 0000", ovf_err); n_fail++; end
  endtask

  task automatic test_dec_blocks_pick();
    for (int k = 0; k < 10; k++) begin
      dec = {1'b0, m_cnt[2] > 0, m_cnt[1] > 0, m_cnt[0] > 0};
      tick();
    end
    dec = 4'b1000;
    #2;
    n_cmp++; if (pick_valid !== 1'b0) begin
      $display("FAIL dec_block: got pick_valid=%b, required 0", pick_valid); n_fail++; end
    dec = '0;
    #2;
    n_cmp++; if (pick_valid !== 1'b1 || pick_idx !== 2'd3) begin
      $display("FAIL dec_release: got v=%b idx=%0d, required v=1 idx=3", pick_valid, pick_idx); n_fail++; end
    tick();
  endtask

  task automatic test_net_zero_and_reset();
    inc_en  = 4'b0001;
    inc_amt = 8'b0000_0001;
    dec     = 4'b0001;
    tick();
    clear_inputs();
    n_cmp++; if (credits[3:0] !== 4'd0 || unf_err[0] !== 1'b0 || ovf_err[0] !== 1'b0) begin
      $display("FAIL net_zero: got cnt0=%0d unf=%b ovf=%b, required 0 0 0", credits[3:0], unf_err[0], ovf_err[0]); n_fail++; end
    dec = 4'b0010;
    tick();
    n_cmp++; if (unf_err !== 4'b0010) begin
      $display("FAIL pre_rst_err: got %b, required 0010", unf_err); n_fail++; end
    rst = 1'b1; pick_req = 1'b1; inc_en = 4'hf; inc_amt = 8'hff;
    tick();
    rst = 1'b0;
    clear_inputs();
    n_cmp++; if (credits !== 16'h8888 || (ovf_err | unf_err) !== 4'h0) begin
      $display("FAIL mid_rst: got cnt=%h ovf=%b unf=%b, required 8888 0 0", credits, ovf_err, unf_err); n_fail++; end
    #2;
    n_cmp++; if (pick_idx !== 2'd0) begin
      $display("FAIL mid_rst_ptr: got %0d, required 0", pick_idx); n_fail++; end
  endtask

  task automatic test_random();
    int p;
    for (int it = 0; it < 400; it++) begin
      rst      = ($urandom_range(0, 99) == 0);
      pick_req = $urandom_range(0, 1);
      err_clr  = ($urandom_range(0, 15) == 0);
      inc_amt  = NUM_CH*INC_W'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        inc_en[c] = ($urandom_range(0, 2) == 0);
        dec[c]    = ($urandom_range(0, 5) == 0);
      end
      #2;
      p = m_pick();
      n_cmp++; if (pick_valid !== (p >= 0)) begin
        $display("FAIL rnd_valid it=%0d: got %b, required %b", it, pick_valid, p >= 0); n_fail++; end
      if (p >= 0) begin
        n_cmp++; if (pick_idx !== IDX_W'(p)) begin
          $display("FAIL rnd_idx it=%0d: got %0d, required %0d", it, pick_idx, p); n_fail++; end
      end
      tick();
      n_cmp++; if (credits !== exp_credits()) begin
        $display("FAIL rnd_credits it=%0d: got %h, required %h", it, credits, exp_credits()); n_fail++; end
      n_cmp++; if (has_credits !== exp_has() || full !== exp_full()) begin
        $display("FAIL rnd_flags it=%0d: got has=%b full=%b, required has=%b full=%b",
                 it, has_credits, full, exp_has(), exp_full()); n_fail++; end
      n_cmp++; if (ovf_err !== exp_ovf() || unf_err !== exp_unf()) begin
        $display("FAIL rnd_err it=%0d: got ovf=%b unf=%b, required ovf=%b unf=%b",
                 it, ovf_err, unf_err, exp_ovf(), exp_unf()); n_fail++; end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_underflow();
    test_overflow();
    test_dec_blocks_pick();
    test_net_zero_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/credit_pool.md
# credit_pool

Multi-channel credit tracker for NUM_CH independent flow-controlled destinations. Each channel holds a saturating credit count with multi-credit returns, sticky overflow/underflow error flags and a configurable reset credit value. A round-robin picker hands out one credit per cycle from any channel that has credits. The block sits between a sender's scheduler and the credit-return paths of downstream buffers.

## Interface
- NUM_CH, 4: number of channels (≥1)
- CREDITS_MAX, 8: per-channel credit capacity
- CREDITS_INIT, CREDITS_MAX: count loaded on reset (0..CREDITS_MAX)
- INC_W, 2: width of a per-cycle credit-return amount
- CNT_WIDTH, $clog2(CREDITS_MAX+1): counter width
- IDX_W, $clog2(NUM_CH) (min 1): channel index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- inc_en  in  NUM_CH  credit return valid per channel
- inc_amt  in  NUM_CH*INC_W  return amount, channel i at [i*INC_W +: INC_W]
- dec  in  NUM_CH  direct one-credit consume per channel
- pick_req  in  1  scheduler requests one credit from any channel
- pick_valid  out  1  a pickable channel exists
- pick_idx  out  IDX_W  channel granted this cycle
- err_clr  in  1  clears all sticky error flags
- credits  out  NUM_CH*CNT_WIDTH  current counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
- has_credits  out  NUM_CH  count > 0
- full  out  NUM_CH  count == CREDITS_MAX
- ovf_err  out  NUM_CH  sticky overflow flag
- unf_err  out  NUM_CH  sticky underflow flag

## Operation
- Reset values: every count = CREDITS_INIT; ovf_err = unf_err = 0; RR pointer = 0; has_credits = (CREDITS_INIT>0); full = (CREDITS_INIT==CREDITS_MAX).
- Channel i is pickable iff has_credits[i] && !dec[i].
- Picker: first pickable channel scanning from RR pointer upward, wrapping mod NUM_CH. pick_valid = any pickable. pick_valid is independent of pick_req.
- Grant = pick_req && pick_valid; on grant, pointer ← (pick_idx+1) mod NUM_CH, else pointer holds.
- Per channel per cycle: add = inc_en ? inc_amt : 0; sub = dec + (grant && pick_idx==i). sub ≤ 1 by construction.
- Arithmetic at width CNT_WIDTH+INC_W+1: sum = count + add.
  - sum < sub: count ← 0, unf_err ← 1.
  - sum − sub > CREDITS_MAX: count ← CREDITS_MAX, ovf_err ← 1.
  - otherwise count ← sum − sub.
- Simultaneous inc and dec on one channel net out; for example, count 0 with add 1 and dec gives 0 and no error.
- err_clr clears flags on the next edge. A new error in the same cycle as err_clr wins, and the flag stays set.
- rst overrides everything, including an in-flight grant or error.

## Timing
- Count, has_credits and full update one cycle after inc/dec/grant. A returned credit is pickable the following cycle.
- pick_valid and pick_idx are combinational from registered counts, pointer and current dec. Zero-latency grant.
- Error flags assert one cycle after the offending event.
- No combinational path from pick_req to pick_valid or pick_idx.

## Structure
- Package credit_pkg holds the clog2-based width helpers and the index/count width constants shared with the sender scheduler.
- Sub-module credit_chan: one saturating counter with sticky errors. Inputs are add, sub and err_clr. Outputs are count, has_credits, full, ovf_err and unf_err. It is generated NUM_CH times.
- Round-robin picker and pointer are inline in credit_pool.

## Test plan
- Reset with CREDITS_INIT=8, NUM_CH=4 -> all counts 8, full=4'b1111, pick_valid=1, pick_idx=0.
- Hold pick_req for 4 cycles from reset -> pick_idx 0,1,2,3; counts each 7 the following cycle; pointer back at 0.
- Channel 1 at count 0, dec[1] pulse -> count stays 0, unf_err[1]=1 next cycle; err_clr one cycle later -> unf_err[1]=0.
- Channel 2 at 7, inc_en=1 with inc_amt=3 -> count 8 (saturated), ovf_err[2]=1; same-cycle err_clr does not clear it.
- Only channel 3 has credits and dec[3]=1 -> pick_valid=0; release dec -> pick_valid=1, pick_idx=3.
- Channel 0 at 0, inc 1 plus dec same cycle -> count 0, no error. Assert rst mid-sequence -> all counts return to CREDITS_INIT and flags clear.
